dbg_bridge_uart_rx: RTL and testbench

UART receive front end of the debug bridge. It deserialises 8N1 frames from the `rxd_i` line, oversampled by a fixed clock divider. Each good byte is presented to the downstream command byte FIFO as a single-cycle push with accept handshake. Framing errors and FIFO overruns are flagged to the bridge status logic.

---
 rtl/dbg_bridge_pkg.sv | 15 +
 rtl/dbg_bridge_sync2.sv | 27 ++
 rtl/dbg_bridge_uart_rx.sv | 149 ++++++++++++++
 tb/tb_dbg_bridge_uart_rx.sv | 208 ++++++++++++++++++++
 4 files changed

// File: rtl/dbg_bridge_pkg.sv
// Shared types and constants for the debug bridge.
// UART receive FSM states and default bit timing.
package dbg_bridge_pkg;

  localparam int UART_DATA_W  = 8;
  localparam int UART_CLK_DIV = 434;

  typedef enum logic [1:0] {
    RX_IDLE  = 2'd0,
    RX_START = 2'd1,
    RX_DATA  = 2'd2,
    RX_STOP  = 2'd3
  } uart_rx_state_t;

endpackage

// File: rtl/dbg_bridge_sync2.sv
// Two-flop synchroniser for asynchronous single-bit inputs.
// Both flops reset to RST_VAL so the output is quiet out of reset.
module dbg_bridge_sync2 #(
  parameter logic RST_VAL = 1'b1
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic d_i,
  output logic q_o
);

  logic r_meta;
  logic r_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_meta <= RST_VAL;
      r_q    <= RST_VAL;
    end else begin
      r_meta <= d_i;
      r_q    <= r_meta;
    end
  end

  assign q_o = r_q;

endmodule

// File: rtl/dbg_bridge_uart_rx.sv
// UART 8N1 receiver feeding the bridge command byte FIFO.
// Re-arms at mid-stop-bit so back-to-back frames are never missed.
module dbg_bridge_uart_rx
  import dbg_bridge_pkg::*;
#(
  parameter int CLK_DIV = UART_CLK_DIV,
  parameter int DIV_W   = 9
) (
  input  logic                   clk_i,
  input  logic                   rst_ni,
  input  logic                   rxd_i,
  output logic [UART_DATA_W-1:0] data_o,
  output logic                   push_o,
  input  logic                   accept_i,
  output logic                   frame_err_o,
  output logic                   overflow_o,
  input  logic                   clear_i
);

  localparam int HALF = CLK_DIV / 2;
  localparam logic [DIV_W-1:0] CNT_HALF = DIV_W'(HALF);
  localparam logic [DIV_W-1:0] CNT_FULL = DIV_W'(CLK_DIV);
  localparam logic [DIV_W-1:0] CNT_ONE  = DIV_W'(1);

  logic w_rxd_s;

  uart_rx_state_t r_state;
  uart_rx_state_t w_state_nxt;

  logic [DIV_W-1:0]       r_cnt;
  logic [DIV_W-1:0]       w_cnt_nxt;
  logic [2:0]             r_idx;
  logic [2:0]             w_idx_nxt;
  logic [UART_DATA_W-1:0] r_shift;
  logic [UART_DATA_W-1:0] w_shift_nxt;
  logic [UART_DATA_W-1:0] r_data;
  logic [UART_DATA_W-1:0] w_data_nxt;
  logic                   r_push;
  logic                   w_push_nxt;
  logic                   r_ferr;
  logic                   w_ferr_nxt;
  logic                   r_ovf;

  dbg_bridge_sync2 #(
    .RST_VAL(1'b1)
  ) u_sync (
    .clk_i (clk_i),
    .rst_ni(rst_ni),
    .d_i   (rxd_i),
    .q_o   (w_rxd_s)
  );

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_state <= RX_IDLE;
      r_cnt   <= '0;
      r_idx   <= '0;
      r_shift <= '0;
      r_data  <= '0;
      r_push  <= 1'b0;
      r_ferr  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      r_idx   <= w_idx_nxt;
      r_shift <= w_shift_nxt;
      r_data  <= w_data_nxt;
      r_push  <= w_push_nxt;
      r_ferr  <= w_ferr_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_idx_nxt   = r_idx;
    w_shift_nxt = r_shift;
    w_data_nxt  = r_data;
    w_push_nxt  = 1'b0;
    w_ferr_nxt  = 1'b0;
    unique case (r_state)
      RX_IDLE: begin
        if (!w_rxd_s) begin
          w_state_nxt = RX_START;
          w_cnt_nxt   = CNT_ONE;
        end
      end
      RX_START: begin
        if (r_cnt == CNT_HALF) begin
          if (w_rxd_s) begin
            w_state_nxt = RX_IDLE;
          end else begin
            w_state_nxt = RX_DATA;
            w_cnt_nxt   = CNT_ONE;
            w_idx_nxt   = 3'd0;
          end
        end else begin
          w_cnt_nxt = r_cnt + CNT_ONE;
        end
      end
      RX_DATA: begin
        if (r_cnt == CNT_FULL) begin
          w_shift_nxt[r_idx] = w_rxd_s;
          w_cnt_nxt          = CNT_ONE;
          w_idx_nxt          = r_idx + 3'd1;
          if (r_idx == 3'd7) begin
            w_state_nxt = RX_STOP;
          end
        end else begin
          w_cnt_nxt = r_cnt + CNT_ONE;
        end
      end
      RX_STOP: begin
        if (r_cnt == CNT_FULL) begin
          w_state_nxt = RX_IDLE;
          w_cnt_nxt   = '0;
          // bad stop bit: drop the byte, flag it instead
          if (w_rxd_s) begin
            w_push_nxt = 1'b1;
            w_data_nxt = r_shift;
          end else begin
            w_ferr_nxt = 1'b1;
          end
        end else begin
          w_cnt_nxt = r_cnt + CNT_ONE;
        end
      end
      default: begin
        w_state_nxt = RX_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_ovf <= 1'b0;
    end else if (r_push && !accept_i) begin
      r_ovf <= 1'b1;
    end else if (clear_i) begin
      r_ovf <= 1'b0;
    end
  end

  assign data_o      = r_data;
  assign push_o      = r_push;
  assign frame_err_o = r_ferr;
  assign overflow_o  = r_ovf;

endmodule

// File: tb/tb_dbg_bridge_uart_rx.sv
// Randomised bench for the UART receiver against a frame-level model.
// Expected bytes and frame errors are queued when each frame is sent.
module tb_dbg_bridge_uart_rx;

  localparam int CLK_DIV = 16;
  localparam int DIV_W   = 5;
  localparam int LAT     = 2 + CLK_DIV / 2 + 9 * CLK_DIV + 1;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       rxd;
  logic       acc;
  logic       clr;
  logic [7:0] data;
  logic       push;
  logic       ferr;
  logic       ovf;

  int n_vec = 0;
  int n_bad = 0;
  int cyc = 0;
  int tx_start = 0;
  int last_push = -1;
  int last_ferr = -1;

  logic [8:0] exp_q[$];
  logic [8:0] mon_e;
  logic       exp_ovf = 1'b0;

  dbg_bridge_uart_rx #(
    .CLK_DIV(CLK_DIV),
    .DIV_W  (DIV_W)
  ) dut (
    .clk_i      (clk),
    .rst_ni     (rst_n),
    .rxd_i      (rxd),
    .data_o     (data),
    .push_o     (push),
    .accept_i   (acc),
    .frame_err_o(ferr),
    .overflow_o (ovf),
    .clear_i    (clr)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // frame-level reference: every stop-bit sample yields one event in order
  always @(negedge clk) begin
    if (!rst_n) begin
      exp_ovf = 1'b0;
    end else begin
      chk("ovf", ovf, exp_ovf);
      if (push || ferr) begin
        if (exp_q.size() == 0) begin
          chk("unexp_evt", {push, ferr}, 0);
        end else begin
          mon_e = exp_q.pop_front();
          chk("evt_kind", {push, ferr}, mon_e[8] ? 2'b01 : 2'b10);
          if (!mon_e[8]) chk("rx_data", data, mon_e[7:0]);
        end
        if (push) last_push = cyc;
        if (ferr) last_ferr = cyc;
      end
      if (push && !acc) exp_ovf = 1'b1;
      else if (clr) exp_ovf = 1'b0;
    end
  end

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // bit k spans [k*P, (k+1)*P) with P = CLK_DIV*(1+e/1000)
  task automatic send_bits(input logic [9:0] bits, input int nb,
                           input int e_pm);
    int t0;
    int t1;
    tx_start = cyc;
    for (int k = 0; k < nb; k++) begin
      rxd = bits[k];
      t0 = (k * CLK_DIV * (1000 + e_pm)) / 1000;
      t1 = ((k + 1) * CLK_DIV * (1000 + e_pm)) / 1000;
      idle(t1 - t0);
    end
  endtask

  task automatic send_frame(input logic [7:0] d, input logic stop,
                            input int e_pm, input int gap);
    exp_q.push_back({~stop, d});
    send_bits({stop, d, 1'b0}, 10, e_pm);
    rxd = 1'b1;
    if (gap > 0) idle(gap);
  endtask

  initial begin
    int e;
    int gap;
    logic bad;
    rst_n = 1'b0;
    rxd   = 1'b1;
    acc   = 1'b1;
    clr   = 1'b0;
    idle(3);
    chk("rst_data", data, 8'h00);
    chk("rst_push", push, 0);
    chk("rst_ferr", ferr, 0);
    chk("rst_ovf", ovf, 0);
    rst_n = 1'b1;
    idle(3);

    send_frame(8'hA5, 1'b1, 0, 20);
    chk("a5_time", last_push, tx_start + LAT);

    tx_start = cyc;
    rxd = 1'b0;
    idle(4);
    rxd = 1'b1;
    idle(5);
    send_frame(8'h96, 1'b1, 0, 20);
    chk("rearm_time", last_push, tx_start + LAT);

    send_frame(8'h3C, 1'b0, 0, 2 * CLK_DIV);
    chk("ferr_time", last_ferr, tx_start + LAT);
    send_frame(8'h55, 1'b1, 0, 20);

    send_frame(8'h00, 1'b1, 0, 0);
    send_frame(8'hFF, 1'b1, 0, 0);
    send_frame(8'h5A, 1'b1, 30, 0);
    send_frame(8'hC7, 1'b1, -30, 20);

    acc = 1'b0;
    send_frame(8'h12, 1'b1, 0, 20);
    acc = 1'b1;
    chk("ovf_held", ovf, 1);
    clr = 1'b1;
    idle(1);
    clr = 1'b0;
    chk("ovf_clr", ovf, 0);

    acc = 1'b0;
    fork
      send_frame(8'h34, 1'b1, 0, 20);
      begin
        idle(5);
        while (cyc < tx_start + LAT) idle(1);
        clr = 1'b1;
        idle(1);
        clr = 1'b0;
      end
    join
    acc = 1'b1;
    chk("ovf_setwins", ovf, 1);
    clr = 1'b1;
    idle(1);
    clr = 1'b0;

    send_bits({1'b1, 8'hC3, 1'b0}, 5, 0);
    rst_n = 1'b0;
    #1;
    chk("mid_data", data, 8'h00);
    chk("mid_push", push, 0);
    chk("mid_ferr", ferr, 0);
    chk("mid_ovf", ovf, 0);
    rxd = 1'b1;
    idle(3);
    rst_n = 1'b1;
    idle(3);
    send_frame(8'h7E, 1'b1, 0, 20);

    for (int i = 0; i < 40; i++) begin
      bad = ($urandom_range(0, 5) == 0);
      if (bad) begin
        e   = int'($urandom_range(0, 30)) - 30;
        gap = 2 * CLK_DIV + int'($urandom_range(0, 8));
      end else begin
        e   = int'($urandom_range(0, 60)) - 30;
        gap = ($urandom_range(0, 2) == 0) ? 0 : int'($urandom_range(1, 24));
      end
      acc = ($urandom_range(0, 7) != 0);
      if ($urandom_range(0, 3) == 0) begin
        clr = 1'b1;
        idle(1);
        clr = 1'b0;
      end
      send_frame(8'($urandom), !bad, e, gap);
    end
    acc = 1'b1;

    for (int w = 0; w < 400 && exp_q.size() != 0; w++) idle(1);
    chk("q_drain", exp_q.size(), 0);
    idle(2);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
